// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 controller state encoding and protocol bytes
package ps2_pkg;
  typedef enum logic [2:0] {SEND, WAIT_TX, WAIT_ACK, FAIL, PKT0, PKT1, PKT2, DONE} state_t;
  localparam logic [7:0] CMD_EN_DEF = 8'hF4;
  localparam logic [7:0] ACK_DEF = 8'hFA;
  localparam logic [7:0] NAK_DEF = 8'hFE;
endpackage

// File: rtl/ps2_mouse_ctrl_timeout_cnt.sv
// ps2_timeout_cnt: saturating cycle counter with expiry flag on the last allowed cycle
module ps2_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (en && cnt != W'(TIMEOUT_CYC)) cnt <= cnt + 1'b1;
  assign expire = en && cnt == W'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/ps2_mouse_ctrl.sv
// ps2_mouse_ctrl: PS/2 mouse init handshake and 3-byte movement packet assembly
module ps2_mouse_ctrl
  import ps2_pkg::*;
#(
  parameter logic [7:0] CMD_EN      = CMD_EN_DEF,
  parameter logic [7:0] ACK_BYTE    = ACK_DEF,
  parameter int         TIMEOUT_CYC = 1_000_000,
  parameter int         MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       tx_idle,
  input  logic       tx_done_tick,
  output logic       rx_en,
  output logic       tx_wr,
  output logic [7:0] tx_data,
  output logic       init_done,
  output logic       init_err,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic [2:0] btn,
  output logic [1:0] ovf,
  output logic       m_done_tick,
  output logic       sync_err_tick
);
  localparam int RW = $clog2(MAX_RETRY + 1);
  state_t state, state_n;
  logic [RW-1:0] retry;
  logic [6:0] b0;
  logic [7:0] b1;
  logic timer_en, timer_clr, expire, try_fail;
  assign timer_en = state inside {WAIT_ACK, PKT1, PKT2};
  assign timer_clr = !timer_en || rx_done_tick;
  assign tx_data = CMD_EN;
  assign init_err = state == FAIL;
  assign m_done_tick = state == DONE;
  ps2_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk(clk), .reset(reset), .clr(timer_clr), .en(timer_en), .expire(expire)
  );
  // a received byte always takes priority over a coincident timeout
  always_comb begin
    state_n = state;
    tx_wr = 1'b0;
    rx_en = 1'b0;
    sync_err_tick = 1'b0;
    try_fail = 1'b0;
    case (state)
      SEND: if (tx_idle) begin
        tx_wr = 1'b1;
        state_n = WAIT_TX;
      end
      WAIT_TX: if (tx_done_tick) state_n = WAIT_ACK;
      WAIT_ACK: begin
        rx_en = 1'b1;
        if (rx_done_tick && rx_data == ACK_BYTE) state_n = PKT0;
        else if (rx_done_tick || expire) begin
          try_fail = 1'b1;
          state_n = retry == RW'(MAX_RETRY - 1) ? FAIL : SEND;
        end
      end
      PKT0: begin
        rx_en = 1'b1;
        if (rx_done_tick) begin
          state_n = rx_data[3] ? PKT1 : PKT0;
          sync_err_tick = !rx_data[3];
        end
      end
      PKT1, PKT2: begin
        rx_en = 1'b1;
        if (rx_done_tick) state_n = state == PKT1 ? PKT2 : DONE;
        else if (expire) begin
          state_n = PKT0;
          sync_err_tick = 1'b1;
        end
      end
      DONE: state_n = PKT0;
      default: state_n = state;
    endcase
  end
  // b0 keeps only the fields used downstream: {b0[7:4], b0[2:0]}
  always_ff @(posedge clk)
    if (reset) begin
      state <= SEND;
      retry <= '0;
      init_done <= 1'b0;
      b0 <= '0;
      b1 <= '0;
      xm <= '0;
      ym <= '0;
      btn <= '0;
      ovf <= '0;
    end else begin
      state <= state_n;
      if (try_fail) retry <= retry + 1'b1;
      if (state == WAIT_ACK && state_n == PKT0) init_done <= 1'b1;
      if (state == PKT0 && state_n == PKT1) b0 <= {rx_data[7:4], rx_data[2:0]};
      if (state == PKT1 && state_n == PKT2) b1 <= rx_data;
      if (state == PKT2 && state_n == DONE) begin
        xm <= {b0[3], b1};
        ym <= {b0[4], rx_data};
        btn <= b0[2:0];
        ovf <= b0[6:5];
      end
    end
endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// tb_ps2_mouse_ctrl: table, hand-written and random checks of the PS/2 mouse controller
module tb_ps2_mouse_ctrl;
  localparam int TO = 100;
  logic clk = 0, reset = 1, rx_done_tick = 0, tx_idle = 0, tx_done_tick = 0;
  logic [7:0] rx_data = 0;
  logic rx_en, tx_wr, init_done, init_err, m_done_tick, sync_err_tick;
  logic [7:0] tx_data;
  logic [8:0] xm, ym;
  logic [2:0] btn;
  logic [1:0] ovf;
  int total = 0, bad = 0, wr_cnt = 0, md_cnt = 0, se_cnt = 0, exp_md = 0;

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic [8:0] xm, ym;
    logic [2:0] btn;
    logic [1:0] ovf;
  } vec_t;

  ps2_mouse_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .tx_idle(tx_idle), .tx_done_tick(tx_done_tick), .rx_en(rx_en), .tx_wr(tx_wr),
    .tx_data(tx_data), .init_done(init_done), .init_err(init_err), .xm(xm), .ym(ym),
    .btn(btn), .ovf(ovf), .m_done_tick(m_done_tick), .sync_err_tick(sync_err_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset) begin
      if (tx_wr) wr_cnt++;
      if (m_done_tick) md_cnt++;
      if (sync_err_tick) se_cnt++;
    end

  function automatic vec_t model(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    vec_t m;
    int dx, dy;
    dx = b0[4] ? int'(b1) - 256 : int'(b1);
    dy = b0[5] ? int'(b2) - 256 : int'(b2);
    m.b0 = b0; m.b1 = b1; m.b2 = b2;
    m.xm = 9'(dx);
    m.ym = 9'(dy);
    m.btn = 3'(int'(b0) % 8);
    m.ovf = 2'(int'(b0) / 64);
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done_tick = 1;
    tick();
    rx_done_tick = 0;
  endtask

  task automatic pulse_txdone();
    tx_done_tick = 1;
    tick();
    tx_done_tick = 0;
  endtask

  // returns at the negedge where the signal is seen; n = cycles waited, -1 on expiry
  task automatic wait_for(input int sel, input int max, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (sel == 0 ? tx_wr : sync_err_tick) return;
      if (n == max) begin
        n = -1;
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1; tx_idle = 0; rx_done_tick = 0; tx_done_tick = 0;
    tick(); tick();
    reset = 0;
  endtask

  task automatic init_seq();
    int n;
    tx_idle = 1;
    wait_for(0, 20, n);
    check("init_wr_seen", 32'(n >= 0), 1);
    tick();
    pulse_txdone();
    send_byte(8'hFA);
    @(negedge clk);
    check("init_done", init_done, 1);
    tick();
  endtask

  task automatic send_pkt(input vec_t v, input int gap);
    send_byte(v.b0);
    repeat (gap) tick();
    send_byte(v.b1);
    repeat (gap) tick();
    send_byte(v.b2);
    @(negedge clk);
    check("m_done", m_done_tick, 1);
    check("xm", xm, v.xm);
    check("ym", ym, v.ym);
    check("btn", btn, v.btn);
    check("ovf", ovf, v.ovf);
    exp_md++;
    tick();
  endtask

  initial begin
    vec_t tbl[5];
    vec_t v;
    int n, se0, md0, w0;
    tbl[0] = '{8'h19, 8'h05, 8'hFE, 9'h105, 9'h0FE, 3'b001, 2'b00};
    tbl[1] = '{8'h08, 8'h00, 8'h00, 9'h000, 9'h000, 3'b000, 2'b00};
    tbl[2] = '{8'h28, 8'h10, 8'h01, 9'h010, 9'h101, 3'b000, 2'b00};
    tbl[3] = '{8'hFF, 8'h80, 8'h7F, 9'h180, 9'h17F, 3'b111, 2'b11};
    tbl[4] = '{8'h4C, 8'hFF, 8'h00, 9'h0FF, 9'h000, 3'b100, 2'b01};

    do_reset();
    @(negedge clk);
    check("rst_tx_wr", tx_wr, 0);
    check("rst_rx_en", rx_en, 0);
    check("rst_init_done", init_done, 0);
    check("rst_init_err", init_err, 0);
    check("rst_tx_data", tx_data, 8'hF4);
    check("rst_xm", xm, 0);
    check("rst_m_done", m_done_tick, 0);
    tick();

    // first init: a stray ACK while the command is still going out must be ignored
    tx_idle = 1;
    wait_for(0, 20, n);
    check("first_wr_seen", 32'(n >= 0), 1);
    check("first_tx_data", tx_data, 8'hF4);
    tick();
    send_byte(8'hFA);
    pulse_txdone();
    @(negedge clk);
    check("wait_ack_init_done", init_done, 0);
    check("wait_ack_rx_en", rx_en, 1);
    tick();
    send_byte(8'hFA);
    @(negedge clk);
    check("ack_init_done", init_done, 1);
    check("pkt0_rx_en", rx_en, 1);
    check("single_tx_wr", wr_cnt, 1);
    tick();

    for (int i = 0; i < 5; i++) send_pkt(tbl[i], i);

    se0 = se_cnt; md0 = md_cnt;
    send_byte(8'h00);
    tick();
    check("bad_b0_sync_err", se_cnt - se0, 1);
    check("bad_b0_no_pkt", md_cnt - md0, 0);
    send_pkt(tbl[1], 0);

    // partial packet times out exactly TO cycles after byte0
    se0 = se_cnt;
    send_byte(8'h08);
    wait_for(1, 3 * TO, n);
    check("pkt1_timeout_cycles", n, TO - 1);
    tick();
    check("pkt1_timeout_cnt", se_cnt - se0, 1);
    send_pkt(tbl[2], 0);

    // byte arriving on the expiry cycle wins
    se0 = se_cnt;
    send_byte(8'h08);
    repeat (TO - 1) tick();
    send_byte(8'h44);
    repeat (TO - 1) tick();
    send_byte(8'h33);
    v = model(8'h08, 8'h44, 8'h33);
    @(negedge clk);
    check("edge_m_done", m_done_tick, 1);
    check("edge_xm", xm, v.xm);
    check("edge_ym", ym, v.ym);
    exp_md++;
    tick();
    check("edge_no_sync_err", se_cnt - se0, 0);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        se0 = se_cnt;
        send_byte(8'($urandom) & 8'hF7);
        tick();
        check("rand_junk_sync_err", se_cnt - se0, 1);
      end
      v = model(8'($urandom) | 8'h08, 8'($urandom), 8'($urandom));
      send_pkt(v, $urandom_range(0, 20));
    end
    check("pkt_count", md_cnt, exp_md);

    // init failure: NAK, timeout, wrong byte
    do_reset();
    w0 = wr_cnt;
    tx_idle = 1;
    wait_for(0, 20, n);
    tick();
    pulse_txdone();
    send_byte(8'hFE);
    wait_for(0, 20, n);
    check("nak_retry_now", n, 0);
    tick();
    pulse_txdone();
    wait_for(0, 3 * TO, n);
    check("ack_timeout_cycles", n, TO);
    tick();
    pulse_txdone();
    send_byte(8'h00);
    @(negedge clk);
    check("fail_init_err", init_err, 1);
    check("fail_rx_en", rx_en, 0);
    check("fail_init_done", init_done, 0);
    tick();
    send_byte(8'hFA);
    repeat (20) tick();
    @(negedge clk);
    check("fail_terminal", init_err, 1);
    check("fail_wr_count", wr_cnt - w0, 3);
    tick();

    // reset in the middle of a packet
    do_reset();
    init_seq();
    send_pkt(tbl[3], 0);
    send_byte(8'h18);
    send_byte(8'h7F);
    reset = 1;
    tx_idle = 0;
    tick();
    @(negedge clk);
    check("mid_rst_xm", xm, 0);
    check("mid_rst_ym", ym, 0);
    check("mid_rst_btn", btn, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_init_done", init_done, 0);
    tick();
    reset = 0;
    md0 = md_cnt;
    tx_idle = 1;
    wait_for(0, 20, n);
    check("mid_rst_resend", 32'(n >= 0), 1);
    check("mid_rst_tx_data", tx_data, 8'hF4);
    tick();
    send_byte(8'h55);
    repeat (5) tick();
    check("mid_rst_no_pkt", md_cnt - md0, 0);
    check("mid_rst_still_init", init_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
